// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with grant hold, timeout release and a 1-cycle REL turnaround.
// Latency: a request sampled at edge N is granted after edge N; release to next grant takes 2 edges.
// Backpressure: none; losing masters must hold req high and win the next contention.
// Optional build macro BUS_ARB_FIXED_PRIORITY_EN: master 1 always wins contention (master 2 may starve).
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_m1,
  input  logic req_m2,
  input  logic done,
  output logic gnt_m1,
  output logic gnt_m2,
  output logic master_select,
  output logic bus_busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2,
    REL  = 2'd3
  } state_t;

  // Hold-counter value on the last permitted grant cycle.
  localparam logic [COUNT_WIDTH-1:0] CNT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] hold_cnt;
  logic [COUNT_WIDTH-1:0] hold_cnt_nxt;
  logic                   gnt_m1_nxt;
  logic                   gnt_m2_nxt;
  logic                   master_select_nxt;
  logic                   bus_busy_nxt;
  logic                   timeout_err_nxt;
  logic                   pick_m1;
  logic                   own_req;
  logic                   at_limit;

`ifndef BUS_ARB_FIXED_PRIORITY_EN
  // 1 = master 2 held the most recent grant, so master 1 wins the next tie.
  logic                   last_m2;
  logic                   last_m2_nxt;
`endif

  // Arbitration winner when leaving IDLE; only meaningful if some request is high.
`ifdef BUS_ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick_m1 = req_m1;
  end
`else
  always_comb begin
    pick_m1 = req_m1 && (!req_m2 || last_m2);
  end
`endif

  // Release conditions for the current owner.
  always_comb begin
    own_req  = (state == GNT1) ? req_m1 : req_m2;
    at_limit = (hold_cnt == CNT_LIMIT);
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt         = state;
    hold_cnt_nxt      = hold_cnt;
    gnt_m1_nxt        = 1'b0;
    gnt_m2_nxt        = 1'b0;
    bus_busy_nxt      = 1'b0;
    timeout_err_nxt   = 1'b0;
    master_select_nxt = master_select;
`ifndef BUS_ARB_FIXED_PRIORITY_EN
    last_m2_nxt       = last_m2;
`endif
    case (state)
      IDLE: begin
        if (req_m1 || req_m2) begin
          hold_cnt_nxt = '0;
          bus_busy_nxt = 1'b1;
          if (pick_m1) begin
            state_nxt         = GNT1;
            gnt_m1_nxt        = 1'b1;
            master_select_nxt = 1'b1;
`ifndef BUS_ARB_FIXED_PRIORITY_EN
            last_m2_nxt       = 1'b0;
`endif
          end else begin
            state_nxt         = GNT2;
            gnt_m2_nxt        = 1'b1;
            master_select_nxt = 1'b0;
`ifndef BUS_ARB_FIXED_PRIORITY_EN
            last_m2_nxt       = 1'b1;
`endif
          end
        end
      end
      GNT1, GNT2: begin
        if (done || !own_req || at_limit) begin
          // done takes precedence: a completed transaction is never flagged as a timeout.
          state_nxt       = REL;
          timeout_err_nxt = at_limit && !done;
        end else begin
          gnt_m1_nxt   = (state == GNT1);
          gnt_m2_nxt   = (state == GNT2);
          bus_busy_nxt = 1'b1;
          if (hold_cnt != CNT_MAX) begin
            hold_cnt_nxt = hold_cnt + CNT_ONE;
          end
        end
      end
      REL: begin
        // One dead cycle so the downstream 2-stage mux/decoder drains before the next owner.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops both grants immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      gnt_m1        <= 1'b0;
      gnt_m2        <= 1'b0;
      bus_busy      <= 1'b0;
      timeout_err   <= 1'b0;
      master_select <= 1'b1;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_cnt_nxt;
      gnt_m1        <= gnt_m1_nxt;
      gnt_m2        <= gnt_m2_nxt;
      bus_busy      <= bus_busy_nxt;
      timeout_err   <= timeout_err_nxt;
      master_select <= master_select_nxt;
    end
  end

`ifndef BUS_ARB_FIXED_PRIORITY_EN
  // Round-robin history; reset as if master 2 went last so master 1 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_m2 <= 1'b1;
    end else begin
      last_m2 <= last_m2_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a transaction-level reference model.
// Latency: outputs checked on the falling edge after each sampling edge.
// Backpressure: not applicable; masters model the hold-request protocol.
module tb_bus_arbiter;

  localparam int TO = 8;

  logic clk;
  logic rst;
  logic req_m1;
  logic req_m2;
  logic done;
  logic gnt_m1;
  logic gnt_m2;
  logic master_select;
  logic bus_busy;
  logic timeout_err;

  int n_chk;
  int n_bad;

  // Reference model: who owns the bus, how many grant cycles so far, turnaround phase.
  int m_owner;   // 0 none, 1 master 1, 2 master 2
  int m_held;    // grant cycles elapsed including the current one
  int m_gap;     // 1 while in the post-release dead cycle (next edge goes idle without granting)
  int m_last;    // master that received the most recent grant
  bit m_sel;
  bit m_to;

  bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .COUNT_WIDTH   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_m1       (req_m1),
    .req_m2       (req_m2),
    .done         (done),
    .gnt_m1       (gnt_m1),
    .gnt_m2       (gnt_m2),
    .master_select(master_select),
    .bus_busy     (bus_busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_held  = 0;
    m_gap   = 0;
    m_last  = 2;
    m_sel   = 1'b1;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_step(input bit r1, input bit r2, input bit d);
    bit own;
    int win;
    m_to = 1'b0;
    if (m_owner != 0) begin
      own = (m_owner == 1) ? r1 : r2;
      if (d || !own || m_held == TO) begin
        m_to    = !d && (m_held == TO);
        m_owner = 0;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (r1 || r2) begin
`ifdef BUS_ARB_FIXED_PRIORITY_EN
      win = r1 ? 1 : 2;
`else
      if (r1 && r2) win = (m_last == 1) ? 2 : 1;
      else          win = r1 ? 1 : 2;
`endif
      m_owner = win;
      m_held  = 1;
      m_last  = win;
      m_sel   = (win == 1);
    end
  endtask

  task automatic check_all();
    check("gnt_m1",        32'(gnt_m1),          32'(m_owner == 1));
    check("gnt_m2",        32'(gnt_m2),          32'(m_owner == 2));
    check("bus_busy",      32'(bus_busy),        32'(m_owner != 0));
    check("master_select", 32'(master_select),   32'(m_sel));
    check("timeout_err",   32'(timeout_err),     32'(m_to));
    check("mutex",         32'(gnt_m1 & gnt_m2), 32'd0);
  endtask

  // One clock: drive at the falling edge, step model on the rising edge, check at the next fall.
  task automatic cycle(input bit r1, input bit r2, input bit d);
    req_m1 = r1;
    req_m2 = r2;
    done   = d;
    @(posedge clk);
    model_step(r1, r2, d);
    @(negedge clk);
    check_all();
  endtask

  // Bounded wait for the model and DUT to return to an idle, arbitrating state.
  task automatic drain();
    for (int i = 0; i < 12 && (m_owner != 0 || m_gap != 0); i++) begin
      cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    check("drain_idle", 32'(bus_busy), 32'd0);
  endtask

  initial begin
    int run_len;
    bit sim_seen;
    bit r1;
    bit r2;
    n_chk  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    req_m1 = 1'b1;
    req_m2 = 1'b1;
    done   = 1'b0;
    model_reset();

    // Reset held with both requests high: no grant may appear.
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt_m1", 32'(gnt_m1),        32'd0);
      check("rst_gnt_m2", 32'(gnt_m2),        32'd0);
      check("rst_sel",    32'(master_select), 32'd1);
      check("rst_busy",   32'(bus_busy),      32'd0);
      check("rst_tmo",    32'(timeout_err),   32'd0);
    end
    rst = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    check("rst_rel_gnt1", 32'(gnt_m1), 32'd1);

    // Round-robin: both request, done on the 4th grant cycle of each transaction.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, (m_owner != 0) && (m_held == 4));
    end
    drain();

    // Timeout: master 2 alone, never done; each grant must last exactly TO cycles.
    run_len = 0;
    for (int i = 0; i < 26; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (gnt_m2) begin
        run_len++;
      end else if (run_len > 0) begin
        check("tmo_len", 32'(run_len), 32'(TO));
        check("tmo_err", 32'(timeout_err), 32'd1);
        run_len = 0;
      end
    end
    drain();

    // done coinciding with the timeout cycle is a normal release.
    sim_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (sim_seen) begin
        cycle(1'b0, 1'b0, 1'b0);
        check("sim_no_tmo", 32'(timeout_err), 32'd0);
        check("sim_rel",    32'(gnt_m2),      32'd0);
        sim_seen = 1'b0;
      end else if (m_owner == 2 && m_held == TO) begin
        cycle(1'b0, 1'b1, 1'b1);
        sim_seen = 1'b1;
      end else begin
        cycle(1'b0, 1'b1, 1'b0);
      end
    end
    drain();

    // Abandon: master 1 drops its request 2 cycles into its grant; master 2 is waiting.
    for (int i = 0; i < 6 && !(m_owner == 1 && m_held == 2); i++) begin
      cycle(1'b1, 1'b1, 1'b0);
    end
    check("abandon_setup", 32'(gnt_m1), 32'd1);
    cycle(1'b0, 1'b1, 1'b0);
    check("abandon_rel", 32'(bus_busy), 32'd0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("abandon_gnt2", 32'(gnt_m2),        32'd1);
    check("abandon_sel",  32'(master_select), 32'd0);

    // Asynchronous reset mid-grant drops the grant before any clock edge.
    #1;
    rst = 1'b0;
    #1;
    check("arst_gnt_m1", 32'(gnt_m1),        32'd0);
    check("arst_gnt_m2", 32'(gnt_m2),        32'd0);
    check("arst_busy",   32'(bus_busy),      32'd0);
    check("arst_sel",    32'(master_select), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic: sticky requests with occasional drops and random done pulses.
    r1 = 1'b0;
    r2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      if ($urandom_range(0, 7) == 0) r2 = ~r2;
      cycle(r1, r2, $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global time limit so a hung run still reports.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter that sits directly upstream of the bus mux/decoder stage.
- Drives master_select to that stage: 1 selects master 1, 0 selects master 2.
- Grants the bus to one master per transaction, using round-robin fairness, and holds the grant until the transaction ends.
- Forces release of the bus on timeout so a hung master cannot lock it.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a grant may be held before forced release. Legal range 2 to 2^COUNT_WIDTH-1.
- COUNT_WIDTH, 8: width of the hold-cycle counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_m1  input  1  master 1 bus request; held high for the whole transaction.
- req_m2  input  1  master 2 bus request; held high for the whole transaction.
- done  input  1  transaction-complete strobe from the slave side; 1-cycle pulse.
- gnt_m1  output  1  grant to master 1.
- gnt_m2  output  1  grant to master 2.
- master_select  output  1  mux select to the downstream mux/decoder stage.
- bus_busy  output  1  high while either grant is high.
- timeout_err  output  1  1-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset values while rst=0:
  - State is IDLE.
  - gnt_m1=0, gnt_m2=0, bus_busy=0, timeout_err=0.
  - master_select=1.
  - last_grant = master 2, so master 1 wins the first contention.
  - Counter is 0.
- Reset mid-transaction drops both grants immediately (asynchronously). Arbitration restarts from IDLE on the first edge after rst returns to 1.
- All outputs are registered. A request sampled at edge N gives a grant visible after edge N (1-cycle latency).
- FSM states: IDLE, GNT1, GNT2, REL.
- IDLE:
  - Only req_m1 high -> GNT1.
  - Only req_m2 high -> GNT2.
  - Both high -> grant the master that is not last_grant.
  - Neither high -> stay in IDLE.
- Entry to GNT1/GNT2:
  - Set the matching gnt, bus_busy=1 and last_grant.
  - master_select = 1 for GNT1, 0 for GNT2.
  - Clear the counter to 0.
- In GNT1/GNT2 the counter increments by 1 each cycle and saturates; it never wraps. Exit to REL on the first of:
  - done=1 (normal release);
  - the owning req dropped to 0 (abandon);
  - counter == TIMEOUT_CYCLES-1 with done=0 (timeout; timeout_err=1 for exactly the REL cycle).
- Simultaneous exit events:
  - done and timeout in the same cycle count as normal release; no timeout_err.
  - done and req drop in the same cycle count as normal release.
- REL:
  - Exactly one cycle with both grants 0 and bus_busy=0. This is the turnaround gap that lets the 2-cycle mux/decoder pipeline drain.
  - Always -> IDLE; the next grant therefore appears 2 edges after release.
- The non-owning master's request is ignored while a grant is active. It is not lost: the master must hold req high, and it wins the next contention by round-robin.
- master_select holds its last value in IDLE and REL; it changes only on grant entry.
- Invariant: gnt_m1 and gnt_m2 are never high together.
- Masters drive all-zero command bits when not granted, so the decoder sees no enables.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIORITY_EN.
- Defined: in IDLE, master 1 always wins when both request. last_grant is unused, so master 2 can starve. Timeout and REL behaviour are unchanged.
- Undefined (default): round-robin as above.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_m1=req_m2=1 -> gnt_m1=gnt_m2=0, master_select=1, timeout_err=0. Release rst -> gnt_m1=1 after the next edge.
- Round-robin: req_m1=req_m2=1 held, done pulsed 4 cycles after each grant -> grants alternate M1, REL gap, M2, REL gap, M1. Each REL cycle has both grants 0. master_select toggles 1, 0, 1.
- Timeout: TIMEOUT_CYCLES=8, req_m2=1 only, done never asserted -> gnt_m2 high for exactly 8 cycles, then 1 REL cycle with timeout_err=1, then regrant of M2 after IDLE.
- Simultaneous done and timeout: TIMEOUT_CYCLES=8, done on the 8th grant cycle -> timeout_err stays 0.
- Abandon: req_m1 drops 2 cycles into its grant while req_m2=1 -> REL for 1 cycle, then gnt_m2=1 and master_select=0.
- BUS_ARB_FIXED_PRIORITY_EN defined, both requesting continuously, done every 3 cycles -> only gnt_m1 ever asserts.
